// File: rtl/binned_memory_reader.sv
// binned_memory_reader: read-side sequencer for the binned memory.
// Snapshots the per-bin entry counts of one page, walks every non-empty bin
// issuing reads {page, bin, entry}, carries a tag alongside each read through
// a READ_LATENCY-deep pipeline and parks returning data in a small FIFO that
// is never overrun thanks to credit-based issue.
// Optional feature macro: BINNED_READER_LAST_EN adds dout_last, flagging the
// final entry of a scan.
//
// Handshake: an entry transfers on a rising clka edge where dout_valid and
// dout_ready are both high; while dout_valid is high and dout_ready is low,
// dout_data/dout_bin/dout_entry (and dout_last) hold steady.
module binned_memory_reader #(
  parameter int RAM_WIDTH    = 14,
  parameter int RAM_DEPTH    = 512,
  parameter int NPAGES       = 4,
  parameter int NBINS        = 8,
  parameter int NENT_W       = 4,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W      = $clog2(RAM_DEPTH),
  localparam int PAGE_W      = $clog2(NPAGES),
  localparam int BIN_W       = $clog2(NBINS)
) (
  input  logic                           clka,
  input  logic                           rstb,
  input  logic                           start,
  input  logic [PAGE_W-1:0]              page,
  input  logic [NPAGES*NBINS*NENT_W-1:0] nent_all,
  output logic [ADDR_W-1:0]              addrb,
  output logic                           enb,
  output logic                           regceb,
  input  logic [RAM_WIDTH-1:0]           doutb,
  output logic [RAM_WIDTH-1:0]           dout_data,
  output logic [BIN_W-1:0]               dout_bin,
  output logic [NENT_W-1:0]              dout_entry,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic                           busy,
`ifdef BINNED_READER_LAST_EN
  output logic                           dout_last,
`endif
  output logic                           done
);

  localparam int FDEPTH = READ_LATENCY + 2;
  localparam int PTR_W  = $clog2(FDEPTH);
  localparam int CNT_W  = $clog2(FDEPTH + 1);
  localparam logic [CNT_W:0]   FDEPTH_C = (CNT_W+1)'(FDEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(FDEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

  state_t              state;
  logic [PAGE_W-1:0]   page_r;
  logic [NENT_W-1:0]   nent_r [NBINS];
  logic [NBINS-1:0]    mask_r;
  logic [BIN_W-1:0]    cur_bin;
  logic [NENT_W-1:0]   cur_entry;

  logic [NENT_W-1:0]   new_nent [NBINS];
  logic [NBINS-1:0]    new_mask;
  logic [BIN_W-1:0]    first_bin;
  logic [BIN_W-1:0]    next_bin;
  logic                next_found;
  logic                last_entry;

  logic                pipe_v   [READ_LATENCY];
  logic [BIN_W-1:0]    pipe_bin [READ_LATENCY];
  logic [NENT_W-1:0]   pipe_ent [READ_LATENCY];
  logic [CNT_W-1:0]    inflight;

  logic [RAM_WIDTH-1:0] f_data [FDEPTH];
  logic [BIN_W-1:0]     f_bin  [FDEPTH];
  logic [NENT_W-1:0]    f_ent  [FDEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_count;

`ifdef BINNED_READER_LAST_EN
  logic                 pipe_last [READ_LATENCY];
  logic                 f_last    [FDEPTH];
  logic                 issue_last;
`endif

  logic                 issue;
  logic                 push;
  logic                 pop;
  logic [CNT_W:0]       occupancy;
  logic [CNT_W:0]       limit;

  // Candidate snapshot for the requested page plus the bin scan decoders.
  always_comb begin
    new_mask   = '0;
    first_bin  = '0;
    next_bin   = '0;
    next_found = 1'b0;
    for (int b = 0; b < NBINS; b++) begin
      new_nent[b] = nent_all[(int'(page) * NBINS + b) * NENT_W +: NENT_W];
      new_mask[b] = |new_nent[b];
    end
    for (int b = NBINS - 1; b >= 0; b--) begin
      if (new_mask[b]) first_bin = BIN_W'(b);
      if (mask_r[b] && (b > int'(cur_bin))) begin
        next_found = 1'b1;
        next_bin   = BIN_W'(b);
      end
    end
    last_entry = (cur_entry == (nent_r[cur_bin] - NENT_W'(1)));
  end

  // Credit check: reads in flight plus FIFO occupancy must leave room,
  // crediting a pop that happens in the same cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CNT_W'(pipe_v[i]);
    occupancy = {1'b0, inflight} + {1'b0, fifo_count};
    limit     = FDEPTH_C + (CNT_W+1)'(pop);
    issue     = (state == ST_SCAN) && (occupancy < limit);
  end

  assign pop        = dout_valid && dout_ready;
  assign push       = pipe_v[READ_LATENCY-1];
  assign enb        = issue;
  assign addrb      = issue ? {page_r, cur_bin, cur_entry} : '0;
  assign regceb     = busy;
  assign dout_valid = (fifo_count != '0);
  assign dout_data  = dout_valid ? f_data[rd_ptr] : '0;
  assign dout_bin   = dout_valid ? f_bin[rd_ptr]  : '0;
  assign dout_entry = dout_valid ? f_ent[rd_ptr]  : '0;
`ifdef BINNED_READER_LAST_EN
  assign issue_last = issue && last_entry && !next_found;
  assign dout_last  = dout_valid ? f_last[rd_ptr] : 1'b0;
`endif

  // Scan sequencer: snapshot, bin/entry walk, drain and completion pulse.
  always_ff @(posedge clka) begin
    if (rstb) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      page_r    <= '0;
      mask_r    <= '0;
      cur_bin   <= '0;
      cur_entry <= '0;
      nent_r    <= '{default: '0};
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            page_r    <= page;
            nent_r    <= new_nent;
            mask_r    <= new_mask;
            busy      <= 1'b1;
            cur_bin   <= first_bin;
            cur_entry <= '0;
            if (new_mask != '0) begin
              state <= ST_SCAN;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (issue) begin
            if (last_entry) begin
              if (next_found) begin
                cur_bin   <= next_bin;
                cur_entry <= '0;
              end else begin
                state <= ST_DRAIN;
              end
            end else begin
              cur_entry <= cur_entry + NENT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if ((inflight == '0) && (fifo_count == '0)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag valid bits of the read-latency pipeline; flushed by reset.
  always_ff @(posedge clka) begin
    if (rstb) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Tag payload (bin, entry, last) travelling with each read.
  always_ff @(posedge clka) begin
    pipe_bin[0] <= cur_bin;
    pipe_ent[0] <= cur_entry;
`ifdef BINNED_READER_LAST_EN
    pipe_last[0] <= issue_last;
`endif
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_bin[i] <= pipe_bin[i-1];
      pipe_ent[i] <= pipe_ent[i-1];
`ifdef BINNED_READER_LAST_EN
      pipe_last[i] <= pipe_last[i-1];
`endif
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count as is.
  always_ff @(posedge clka) begin
    if (rstb) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage: returning data written together with the exiting tag.
  always_ff @(posedge clka) begin
    if (push) begin
      f_data[wr_ptr] <= doutb;
      f_bin[wr_ptr]  <= pipe_bin[READ_LATENCY-1];
      f_ent[wr_ptr]  <= pipe_ent[READ_LATENCY-1];
`ifdef BINNED_READER_LAST_EN
      f_last[wr_ptr] <= pipe_last[READ_LATENCY-1];
`endif
    end
  end

endmodule

// File: tb/tb_binned_memory_reader.sv
// Testbench for binned_memory_reader: BRAM model with two-cycle latency,
// scoreboard fed from a per-page list model of the expected stream.
module tb_binned_memory_reader;

  localparam int FD = 4;

  logic         clka = 1'b0;
  logic         rstb = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   page = '0;
  logic [127:0] nent_all = '0;
  logic [8:0]   addrb;
  logic         enb;
  logic         regceb;
  logic [13:0]  doutb = '0;
  logic [13:0]  dout_data;
  logic [2:0]   dout_bin;
  logic [3:0]   dout_entry;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         busy;
  logic         done;
`ifdef BINNED_READER_LAST_EN
  logic         dout_last;
`endif

  binned_memory_reader dut (
    .clka(clka), .rstb(rstb), .start(start), .page(page), .nent_all(nent_all),
    .addrb(addrb), .enb(enb), .regceb(regceb), .doutb(doutb),
    .dout_data(dout_data), .dout_bin(dout_bin), .dout_entry(dout_entry),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
`ifdef BINNED_READER_LAST_EN
    .dout_last(dout_last),
`endif
    .done(done)
  );

  // clock / reset block
  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  // memory model: data appears two cycles after enb
  logic [13:0] mem [512];
  logic [13:0] rd1 = '0;
  always @(posedge clka) begin
    rd1   <= enb ? mem[addrb] : 14'h0;
    doutb <= rd1;
  end

  // scoreboard state
  logic [21:0] exp_q[$];      // {last, bin, entry, data}
  logic [8:0]  exp_addr_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int tb_nent [4][8];

  bit          mon_en = 1'b0;
  int          issued = 0, pops = 0, done_cnt = 0, busy_cycles = 0;
  int          start_cyc = 0, first_valid_cyc = -1, last_pop_cyc = -1, done_cyc = -1;
  int          first_issue_cyc = -1, last_issue_cyc = -1, base_done = 0;
  bit          hold_v = 1'b0;
  logic [21:0] hold_w = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] cur_word();
    logic [21:0] w;
    w = {1'b0, dout_bin, dout_entry, dout_data};
`ifdef BINNED_READER_LAST_EN
    w[21] = dout_last;
`endif
    return w;
  endfunction

  // monitor: address order, stream order, stall stability, credit bound
  always @(negedge clka) begin
    if (mon_en) begin
      if (enb) begin
        issued++;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        if (exp_addr_q.size() == 0) check("unexpected_issue", {23'h0, addrb}, 32'hffff_ffff);
        else check("addrb", {23'h0, addrb}, {23'h0, exp_addr_q.pop_front()});
      end
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (hold_v) begin
        check("stall_valid", {31'h0, dout_valid}, 32'h1);
        check("stall_word", {10'h0, cur_word()}, {10'h0, hold_w});
      end
      hold_v = dout_valid && !dout_ready;
      hold_w = cur_word();
      if (dout_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (dout_ready) begin
          pops++;
          last_pop_cyc = cyc;
          if (exp_q.size() == 0) check("unexpected_pop", {10'h0, cur_word()}, 32'hffff_ffff);
          else begin
            logic [21:0] e;
            e = exp_q.pop_front();
`ifndef BINNED_READER_LAST_EN
            e[21] = 1'b0;
`endif
            check("stream_word", {10'h0, cur_word()}, {10'h0, e});
          end
        end
      end
      if (issued - pops > FD) check("credit_bound", issued - pops, FD);
    end
  end

  // driver tasks
  task automatic apply_nent();
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 8; b++)
        nent_all[(p*8+b)*4 +: 4] = 4'(tb_nent[p][b]);
  endtask

  // reference model: every non-empty bin in ascending order, entries 0..n-1
  task automatic load_expect(input int p);
    logic [21:0] w;
    int a;
    for (int b = 0; b < 8; b++)
      for (int e = 0; e < tb_nent[p][b]; e++) begin
        a = p*128 + b*16 + e;
        exp_addr_q.push_back(9'(a));
        w = {1'b0, 3'(b), 4'(e), mem[a]};
        exp_q.push_back(w);
      end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1][21] = 1'b1;
  endtask

  task automatic step(input bit rdy);
    @(posedge clka); #1;
    start = 1'b0;
    dout_ready = rdy;
  endtask

  task automatic pulse_start(input int p);
    @(posedge clka); #1;
    start = 1'b1;
    page = 2'(p);
    start_cyc = cyc;
    first_valid_cyc = -1;
    first_issue_cyc = -1;
    busy_cycles = 0;
    base_done = done_cnt;
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0 repeating, 2: random
  task automatic run_until_done(input int mode, input int bound, input string tag);
    bit got_done = 1'b0;
    bit r;
    for (int k = 0; k < bound && !got_done; k++) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 3) == 0) : 1'($urandom_range(0, 1));
      step(r);
      if (done_cnt != base_done) got_done = 1'b1;
    end
    check({tag, "_done_seen"}, {31'h0, got_done}, 32'h1);
    repeat (3) step(1'b1);
    check({tag, "_done_count"}, done_cnt - base_done, 1);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_addr_left"}, exp_addr_q.size(), 0);
    check({tag, "_busy_low"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic set_scenario_a();
    int v[8] = '{2, 0, 0, 3, 0, 0, 0, 1};
    for (int b = 0; b < 8; b++) tb_nent[1][b] = v[b];
    apply_nent();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 0);
    check({tag, "_done"}, {31'h0, done}, 0);
    check({tag, "_enb"}, {31'h0, enb}, 0);
    check({tag, "_regceb"}, {31'h0, regceb}, 0);
    check({tag, "_addrb"}, {23'h0, addrb}, 0);
    check({tag, "_valid"}, {31'h0, dout_valid}, 0);
    check({tag, "_data"}, {10'h0, dout_data, dout_bin, dout_entry}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 14'($urandom);
    for (int p = 0; p < 4; p++) for (int b = 0; b < 8; b++) tb_nent[p][b] = 0;
    apply_nent();

    // reset state
    rstb = 1'b1;
    repeat (3) @(posedge clka);
    #1;
    check_idle_outputs("reset");
    rstb = 1'b0;
    mon_en = 1'b1;

    // sparse page 1, ready always high
    set_scenario_a();
    load_expect(1);
    pulse_start(1);
    run_until_done(0, 200, "page1");
    check("page1_first_valid", first_valid_cyc - start_cyc, 4);
    check("page1_first_issue", first_issue_cyc - start_cyc, 1);
    check("page1_issue_span", last_issue_cyc - first_issue_cyc, 5);
    check("page1_done_after_pop", {31'h0, done_cyc > last_pop_cyc}, 1);

    // empty page 2; a start in the done cycle is ignored
    begin
      int iss0;
      iss0 = issued;
      pulse_start(2);
      @(posedge clka); #1;
      start = 1'b1;
      page = 2'd1;
      repeat (6) step(1'b1);
      check("empty_done_cycle", done_cyc - start_cyc, 1);
      check("empty_done_count", done_cnt - base_done, 1);
      check("empty_busy_cycles", busy_cycles, 1);
      check("empty_no_issue", issued - iss0, 0);
      check("empty_no_valid", first_valid_cyc, -1);
    end

    // one full bin of 15 entries with a stalling consumer
    for (int b = 0; b < 8; b++) tb_nent[0][b] = (b == 5) ? 15 : 0;
    apply_nent();
    load_expect(0);
    pulse_start(0);
    run_until_done(1, 400, "bin15");

    // counts changed and start repeated mid-scan
    for (int b = 0; b < 8; b++) tb_nent[3][b] = $urandom_range(1, 15);
    apply_nent();
    load_expect(3);
    pulse_start(3);
    repeat (4) step(1'b1);
    for (int b = 0; b < 8; b++) tb_nent[3][b] = $urandom_range(0, 15);
    tb_nent[0][1] = 7;
    apply_nent();
    @(posedge clka); #1;
    start = 1'b1;
    page = 2'd0;
    run_until_done(2, 800, "snapshot");

    // reset in the middle of a scan
    set_scenario_a();
    load_expect(1);
    pulse_start(1);
    step(1'b1);
    step(1'b1);
    @(posedge clka); #1;
    rstb = 1'b1;
    mon_en = 1'b0;
    @(posedge clka); #1;
    rstb = 1'b0;
    check_idle_outputs("midreset");
    begin
      int late_v, late_d, late_e;
      late_v = 0; late_d = 0; late_e = 0;
      for (int k = 0; k < 8; k++) begin
        step(1'b1);
        late_v += int'(dout_valid);
        late_d += int'(done);
        late_e += int'(enb);
      end
      check("midreset_late_valid", late_v, 0);
      check("midreset_late_done", late_d, 0);
      check("midreset_late_enb", late_e, 0);
    end
    exp_q.delete();
    exp_addr_q.delete();
    issued = 0;
    pops = 0;
    hold_v = 1'b0;
    mon_en = 1'b1;
    load_expect(1);
    pulse_start(1);
    run_until_done(0, 200, "after_reset");
    check("after_reset_first_valid", first_valid_cyc - start_cyc, 4);

    // randomized pages and consumers
    for (int r = 0; r < 6; r++) begin
      int p;
      p = $urandom_range(0, 3);
      for (int b = 0; b < 8; b++)
        tb_nent[p][b] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      apply_nent();
      load_expect(p);
      pulse_start(p);
      run_until_done(2, 1500, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/binned_memory_reader.md
Name: binned_memory_reader

Overview:
- Read-side sequencer for the binned VM-stub memory: given a page, walks every non-empty bin and streams the stored entries out with valid/ready flow control.
- Snapshots the page's per-bin entry counts (nent) at start, then generates read addresses {page, bin, entry} and drives enb/regceb.
- Absorbs the fixed BRAM read latency in a credit-controlled skid FIFO.
- Sits between the binned memory read port and the downstream consumer (e.g. match engine).

Parameters:
- RAM_WIDTH, 14, entry data width.
- RAM_DEPTH, 512, memory depth; ADDR_W = clog2(RAM_DEPTH).
- NPAGES, 4, pages in memory; PAGE_W = clog2(NPAGES).
- NBINS, 8, bins per page; BIN_W = clog2(NBINS).
- NENT_W, 4, nent width; entries per bin = RAM_DEPTH/(NPAGES*NBINS) = 16.
- READ_LATENCY, 2, BRAM addr-to-data cycles: 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE.

Ports:
- clka  in  1  clock.
- rstb  in  1  reset, synchronous, active-high.
- start  in  1  begin scan of page; ignored unless busy=0.
- page  in  PAGE_W  page to scan; sampled with start.
- nent_all  in  NPAGES*NBINS*NENT_W  all nent counters; page p bin b at bits [(p*NBINS+b)*NENT_W +: NENT_W].
- addrb  out  ADDR_W  read address = {page, bin, entry}.
- enb  out  1  read enable; high only on issue cycles.
- regceb  out  1  output register enable; equals busy.
- doutb  in  RAM_WIDTH  memory read data, valid READ_LATENCY cycles after enb.
- dout_data  out  RAM_WIDTH  streamed entry.
- dout_bin  out  BIN_W  bin of dout_data.
- dout_entry  out  NENT_W  index within bin.
- dout_valid  out  1  FIFO head valid.
- dout_ready  in  1  consumer accepts when high with dout_valid.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan completion.

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO and in-flight pipeline flushed. Reset mid-scan aborts silently with no done pulse.
- States:
  - IDLE: on start, snapshot the NBINS nent values of page into local registers (later nent_all changes are ignored), compute nonzero-bin mask, set busy. Go to SCAN if mask != 0, else to DONE.
  - SCAN: each cycle, if credit is available, issue one read (enb=1, addrb={page,cur_bin,cur_entry}) and increment cur_entry. When cur_entry == nent[cur_bin]-1 on issue, jump to the lowest nonzero bin > cur_bin (priority encoder, no bubble). If none remains, go to DRAIN. The first bin is the lowest nonzero bin.
  - DRAIN: wait until in-flight count == 0 and FIFO empty, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Latency pipeline: shift register of depth READ_LATENCY carrying {valid, bin, entry} tags. Data is pushed into the FIFO together with its tag on the cycle the tag exits.
- FIFO: depth READ_LATENCY+2. Credit rule: issue only if inflight + fifo_count < depth, counting same-cycle pops. The FIFO never overflows; doutb is never dropped.
- Output: dout_valid = FIFO not empty. Pop on dout_valid & dout_ready. Simultaneous push and pop keeps the count unchanged. Data, bin and entry hold stable while valid and not ready.
- Timing: with dout_ready=1, first dout_valid occurs READ_LATENCY+2 cycles after the start cycle; sustained throughput is 1 entry/cycle.
- Widths: cur_entry is NENT_W bits; nent=15 yields entries 0..14. Address is the concatenation, no arithmetic carry.
- start during busy is ignored. start in the DONE cycle is ignored.

Optional Feature:
- Macro BINNED_READER_LAST_EN.
- Defined: adds output dout_last (1 bit), high with the final entry of the scan. The last tag is carried through the pipeline and FIFO.
- Undefined: no dout_last port and no last-tag storage; completion is signalled by done only.

Test Plan:
- Page 1, nent bins 0..7 = {2,0,0,3,0,0,0,1}, ready=1, READ_LATENCY=2 -> addrb 0x080,0x081,0x0B0,0x0B1,0x0B2,0x0F0 on consecutive cycles. dout (bin,entry) = (0,0),(0,1),(3,0),(3,1),(3,2),(7,0); first valid 4 cycles after start; single done pulse after last pop.
- Empty page 2 (all nent 0), start -> no enb, no dout_valid, done pulses the cycle after start, busy high exactly 1 cycle.
- Page 0 bin 5 nent=15, dout_ready toggled 1,0,0,1,... -> all 15 entries delivered in order 0..14. Data stable during stalls; inflight+fifo_count never exceeds 4.
- Scan active, nent_all for the scanned page changed mid-scan and a second start issued -> snapshot counts used, start ignored, exactly one done.
- rstb asserted mid-SCAN with 2 reads in flight -> all outputs 0 next cycle, no late dout_valid, no done. Next start scans normally.
- With BINNED_READER_LAST_EN defined, first scenario -> dout_last=1 only with (7,0).
